// File: rtl/alu16_seq_if.sv
// alu16_seq_if: request/response handshake and ALU load-port bundle for alu16_seq.
// The slave modport is the sequencer's view; the master modport is the view of
// whoever issues requests, consumes responses and provides the ALU.
interface alu16_seq_if #(
    parameter int BIT_WIDTH = 16
);
    logic                 req_valid;
    logic                 req_ready;
    logic [BIT_WIDTH-1:0] req_a;
    logic [BIT_WIDTH-1:0] req_b;
    logic [3:0]           req_op;

    logic [BIT_WIDTH-1:0] alu_t;
    logic [1:0]           alu_m;
    logic [BIT_WIDTH:0]   alu_f;
    logic                 alu_c;
    logic                 alu_z;
    logic                 alu_n;
    logic                 alu_ov;

    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [BIT_WIDTH:0]   rsp_f;
    logic [3:0]           rsp_flags;

    modport slave (
        input  req_valid, req_a, req_b, req_op,
        input  alu_f, alu_c, alu_z, alu_n, alu_ov,
        input  rsp_ready,
        output req_ready, alu_t, alu_m,
        output rsp_valid, rsp_f, rsp_flags
    );

    modport master (
        output req_valid, req_a, req_b, req_op,
        output alu_f, alu_c, alu_z, alu_n, alu_ov,
        output rsp_ready,
        input  req_ready, alu_t, alu_m,
        input  rsp_valid, rsp_f, rsp_flags
    );
endinterface

// File: rtl/alu16_seq.sv
// alu16_seq: serialises operand A, operand B and the opcode onto the shared ALU
// load port (T/M), waits SETTLE cycles and captures the ALU result and flags
// into a held response. One transaction in flight at a time.
// Optional feature macro: ALU16_UNARY_SKIP_EN -- B-independent opcodes skip the
// operand-B load cycle.
module alu16_seq #(
    parameter int BIT_WIDTH = 16,
    parameter int SETTLE    = 1
) (
    input logic        clk,
    input logic        rst,
    alu16_seq_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LDA,
        S_LDB,
        S_LDS,
        S_WAIT,
        S_RESP
    } state_t;

    localparam logic [1:0] M_LOAD_A  = 2'b00;
    localparam logic [1:0] M_LOAD_B  = 2'b01;
    localparam logic [1:0] M_LOAD_OP = 2'b11;
    localparam logic [1:0] M_HOLD    = 2'b10;

    state_t               state_q,     state_d;
    logic [3:0]           cnt_q,       cnt_d;
    logic [BIT_WIDTH-1:0] a_q,         a_d;
    logic [BIT_WIDTH-1:0] b_q,         b_d;
    logic [3:0]           op_q,        op_d;
    logic                 req_ready_q, req_ready_d;
    logic [1:0]           alu_m_q,     alu_m_d;
    logic [BIT_WIDTH-1:0] alu_t_q,     alu_t_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [BIT_WIDTH:0]   rsp_f_q,     rsp_f_d;
    logic [3:0]           rsp_flags_q, rsp_flags_d;
    logic                 op_is_unary;

    // Flag opcodes whose result does not depend on operand B (only when skipping is built in).
    always_comb begin
        op_is_unary = 1'b0;
`ifdef ALU16_UNARY_SKIP_EN
        case (op_q)
            4'b0011, 4'b0100, 4'b0111, 4'b1000,
            4'b1001, 4'b1010, 4'b1011: op_is_unary = 1'b1;
            default:                   op_is_unary = 1'b0;
        endcase
`endif
    end

    // Next-state and next-output logic; bus drive for a state lands on the edge that leaves it.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        req_ready_d = 1'b0;
        alu_m_d     = M_HOLD;
        alu_t_d     = '0;
        rsp_valid_d = rsp_valid_q;
        rsp_f_d     = rsp_f_q;
        rsp_flags_d = rsp_flags_q;

        case (state_q)
            S_IDLE: begin
                req_ready_d = 1'b1;
                if (bus.req_valid && req_ready_q) begin
                    a_d         = bus.req_a;
                    b_d         = bus.req_b;
                    op_d        = bus.req_op;
                    req_ready_d = 1'b0;
                    state_d     = S_LDA;
                end
            end
            S_LDA: begin
                alu_m_d = M_LOAD_A;
                alu_t_d = a_q;
                state_d = op_is_unary ? S_LDS : S_LDB;
            end
            S_LDB: begin
                alu_m_d = M_LOAD_B;
                alu_t_d = b_q;
                state_d = S_LDS;
            end
            S_LDS: begin
                alu_m_d = M_LOAD_OP;
                alu_t_d = {{(BIT_WIDTH-4){1'b0}}, op_q};
                cnt_d   = 4'(SETTLE);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    cnt_d       = '0;
                    rsp_f_d     = bus.alu_f;
                    rsp_flags_d = {bus.alu_c, bus.alu_z, bus.alu_n, bus.alu_ov};
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset aborts any transaction immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            req_ready_q <= 1'b1;
            alu_m_q     <= M_HOLD;
            alu_t_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_f_q     <= '0;
            rsp_flags_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            req_ready_q <= req_ready_d;
            alu_m_q     <= alu_m_d;
            alu_t_q     <= alu_t_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_f_q     <= rsp_f_d;
            rsp_flags_q <= rsp_flags_d;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.alu_m     = alu_m_q;
    assign bus.alu_t     = alu_t_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_f     = rsp_f_q;
    assign bus.rsp_flags = rsp_flags_q;

endmodule

// File: tb/tb_alu16_seq.sv
// tb_alu16_seq: directed bench for alu16_seq with a small latching ALU model on the load port.
// Honours ALU16_UNARY_SKIP_EN for the unary-opcode expectations.
module tb_alu16_seq;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

`ifdef ALU16_UNARY_SKIP_EN
    localparam int UNARY_LAT   = 3;
    localparam bit UNARY_SEE01 = 1'b0;
`else
    localparam int UNARY_LAT   = 4;
    localparam bit UNARY_SEE01 = 1'b1;
`endif

    alu16_seq_if #(.BIT_WIDTH(16)) bus ();

    alu16_seq #(.BIT_WIDTH(16), .SETTLE(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ALU input latches: captured when M selects them, transparent while selected.
    logic [15:0] la = '0;
    logic [15:0] lb = '0;
    logic [3:0]  lop = '0;

    // Latch update on the rising edge with the M/T values present before the edge.
    always @(posedge clk) begin
        if (bus.alu_m == 2'b00) la  <= bus.alu_t;
        if (bus.alu_m == 2'b01) lb  <= bus.alu_t;
        if (bus.alu_m == 2'b11) lop <= bus.alu_t[3:0];
    end

    logic [15:0] ea, eb, r16;
    logic [3:0]  eop;
    logic [16:0] f;

    // Combinational ALU: ADD, SUB, INC modelled; anything else gives F=0 (Z=1).
    always_comb begin
        ea  = (bus.alu_m == 2'b00) ? bus.alu_t : la;
        eb  = (bus.alu_m == 2'b01) ? bus.alu_t : lb;
        eop = (bus.alu_m == 2'b11) ? bus.alu_t[3:0] : lop;
        f   = '0;
        r16 = '0;
        bus.alu_c  = 1'b0;
        bus.alu_ov = 1'b0;
        case (eop)
            4'b0001: begin
                f          = {1'b0, ea} + {1'b0, eb};
                bus.alu_c  = f[16];
                bus.alu_ov = (ea[15] == eb[15]) && (f[15] != ea[15]);
            end
            4'b0010: begin
                r16        = ea - eb;
                f          = {1'b0, r16};
                bus.alu_c  = (ea >= eb);
                bus.alu_ov = (ea[15] != eb[15]) && (r16[15] != ea[15]);
            end
            4'b0011: begin
                r16        = ea + 16'd1;
                f          = {1'b0, r16};
                bus.alu_c  = (ea == 16'hFFFF);
                bus.alu_ov = (ea == 16'h7FFF);
            end
            default: f = '0;
        endcase
        bus.alu_f = f;
        bus.alu_z = (f == 17'd0);
        bus.alu_n = f[16];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for req_ready, then present one request across its accept edge.
    task automatic do_request(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op);
        int n;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            tick();
            n++;
        end
        if (!bus.req_ready) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL req_ready_timeout: got %b expected 1", bus.req_ready);
        end
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_op    = op;
        bus.req_valid = 1'b1;
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_op    = '0;
        bus.rsp_ready = 1'b0;
        #12;
        vectors++;
        if (bus.req_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_req_ready: got %b expected 1", bus.req_ready);
        end
        vectors++;
        if ({bus.alu_m, bus.alu_t} !== {2'b10, 16'h0000}) begin
            miscompares++;
            $display("[TB] FAIL reset_bus: got %b/%h expected 10/0000", bus.alu_m, bus.alu_t);
        end
        vectors++;
        if ({bus.rsp_valid, bus.rsp_f, bus.rsp_flags} !== 22'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_rsp: got %b/%h/%b expected 0/00000/0000",
                     bus.rsp_valid, bus.rsp_f, bus.rsp_flags);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        vectors++;
        if ({bus.req_ready, bus.alu_m} !== 3'b110) begin
            miscompares++;
            $display("[TB] FAIL post_reset_idle: got %b/%b expected 1/10", bus.req_ready, bus.alu_m);
        end
    endtask

    task automatic test_add_overflow();
        bus.rsp_ready = 1'b1;
        do_request(16'h7FFF, 16'h0001, 4'b0001);
        tick();
        vectors++;
        if ({bus.alu_m, bus.alu_t} !== {2'b00, 16'h7FFF}) begin
            miscompares++;
            $display("[TB] FAIL add_lda: got %b/%h expected 00/7fff", bus.alu_m, bus.alu_t);
        end
        vectors++;
        if (bus.req_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL add_busy_ready: got %b expected 0", bus.req_ready);
        end
        tick();
        vectors++;
        if ({bus.alu_m, bus.alu_t} !== {2'b01, 16'h0001}) begin
            miscompares++;
            $display("[TB] FAIL add_ldb: got %b/%h expected 01/0001", bus.alu_m, bus.alu_t);
        end
        tick();
        vectors++;
        if ({bus.alu_m, bus.alu_t, bus.rsp_valid} !== {2'b11, 16'h0001, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL add_lds: got %b/%h/%b expected 11/0001/0",
                     bus.alu_m, bus.alu_t, bus.rsp_valid);
        end
        tick();
        vectors++;
        if ({bus.alu_m, bus.alu_t, bus.rsp_valid} !== {2'b10, 16'h0000, 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL add_wait_capture: got %b/%h/%b expected 10/0000/1",
                     bus.alu_m, bus.alu_t, bus.rsp_valid);
        end
        vectors++;
        if (bus.rsp_f !== 17'h08000) begin
            miscompares++;
            $display("[TB] FAIL add_rsp_f: got %h expected 08000", bus.rsp_f);
        end
        vectors++;
        if (bus.rsp_flags !== 4'b0001) begin
            miscompares++;
            $display("[TB] FAIL add_rsp_flags: got %b expected 0001", bus.rsp_flags);
        end
        tick();
        vectors++;
        if ({bus.rsp_valid, bus.req_ready} !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL add_handshake: got %b/%b expected 0/0", bus.rsp_valid, bus.req_ready);
        end
        tick();
        vectors++;
        if (bus.req_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL add_ready_return: got %b expected 1", bus.req_ready);
        end
    endtask

    task automatic test_sub_zero();
        int lat;
        bus.rsp_ready = 1'b1;
        do_request(16'h0005, 16'h0005, 4'b0010);
        lat = 0;
        while (!bus.rsp_valid && lat < 20) begin
            tick();
            lat++;
        end
        vectors++;
        if (lat != 4) begin
            miscompares++;
            $display("[TB] FAIL sub_latency: got %0d expected 4", lat);
        end
        vectors++;
        if (bus.rsp_f !== 17'h00000) begin
            miscompares++;
            $display("[TB] FAIL sub_rsp_f: got %h expected 00000", bus.rsp_f);
        end
        vectors++;
        if (bus.rsp_flags !== 4'b1100) begin
            miscompares++;
            $display("[TB] FAIL sub_rsp_flags: got %b expected 1100", bus.rsp_flags);
        end
        tick();
        tick();
    endtask

    task automatic test_backpressure();
        int lat;
        bus.rsp_ready = 1'b0;
        do_request(16'hFFFF, 16'h0002, 4'b0001);
        lat = 0;
        while (!bus.rsp_valid && lat < 20) begin
            tick();
            lat++;
        end
        vectors++;
        if (lat != 4) begin
            miscompares++;
            $display("[TB] FAIL bp_latency: got %0d expected 4", lat);
        end
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                bus.req_a     = 16'h1234;
                bus.req_valid = 1'b1;
            end
            tick();
            bus.req_valid = 1'b0;
            vectors++;
            if ({bus.rsp_valid, bus.rsp_f, bus.rsp_flags} !== {1'b1, 17'h10001, 4'b1010}) begin
                miscompares++;
                $display("[TB] FAIL bp_hold[%0d]: got %b/%h/%b expected 1/10001/1010",
                         i, bus.rsp_valid, bus.rsp_f, bus.rsp_flags);
            end
            vectors++;
            if ({bus.req_ready, bus.alu_m} !== 3'b010) begin
                miscompares++;
                $display("[TB] FAIL bp_bus[%0d]: got %b/%b expected 0/10", i, bus.req_ready, bus.alu_m);
            end
        end
        bus.rsp_ready = 1'b1;
        tick();
        vectors++;
        if (bus.rsp_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL bp_release: got %b expected 0", bus.rsp_valid);
        end
        tick();
        vectors++;
        if (bus.req_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL bp_ready_return: got %b expected 1", bus.req_ready);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if ({bus.alu_m, bus.req_ready} !== 3'b101) begin
                miscompares++;
                $display("[TB] FAIL bp_not_queued[%0d]: got %b/%b expected 10/1", i, bus.alu_m, bus.req_ready);
            end
        end
    endtask

    task automatic test_abort_recover();
        bus.rsp_ready = 1'b1;
        do_request(16'h1111, 16'h2222, 4'b0001);
        tick();
        vectors++;
        if ({bus.alu_m, bus.alu_t} !== {2'b00, 16'h1111}) begin
            miscompares++;
            $display("[TB] FAIL abort_pre_lda: got %b/%h expected 00/1111", bus.alu_m, bus.alu_t);
        end
        #3;
        rst = 1'b1;
        #1;
        vectors++;
        if ({bus.req_ready, bus.alu_m, bus.alu_t} !== {1'b1, 2'b10, 16'h0000}) begin
            miscompares++;
            $display("[TB] FAIL abort_bus: got %b/%b/%h expected 1/10/0000",
                     bus.req_ready, bus.alu_m, bus.alu_t);
        end
        vectors++;
        if ({bus.rsp_valid, bus.rsp_f, bus.rsp_flags} !== 22'd0) begin
            miscompares++;
            $display("[TB] FAIL abort_rsp: got %b/%h/%b expected 0/00000/0000",
                     bus.rsp_valid, bus.rsp_f, bus.rsp_flags);
        end
        @(negedge clk);
        rst = 1'b0;
        do_request(16'h0003, 16'h0004, 4'b0001);
        tick();
        vectors++;
        if ({bus.alu_m, bus.alu_t} !== {2'b00, 16'h0003}) begin
            miscompares++;
            $display("[TB] FAIL recover_lda: got %b/%h expected 00/0003", bus.alu_m, bus.alu_t);
        end
        tick();
        vectors++;
        if ({bus.alu_m, bus.alu_t} !== {2'b01, 16'h0004}) begin
            miscompares++;
            $display("[TB] FAIL recover_ldb: got %b/%h expected 01/0004", bus.alu_m, bus.alu_t);
        end
        tick();
        tick();
        vectors++;
        if ({bus.rsp_valid, bus.rsp_f, bus.rsp_flags} !== {1'b1, 17'h00007, 4'b0000}) begin
            miscompares++;
            $display("[TB] FAIL recover_rsp: got %b/%h/%b expected 1/00007/0000",
                     bus.rsp_valid, bus.rsp_f, bus.rsp_flags);
        end
        tick();
        tick();
    endtask

    task automatic test_unary();
        int lat;
        bit saw01;
        bus.rsp_ready = 1'b1;
        do_request(16'hFFFF, 16'hABCD, 4'b0011);
        lat   = 0;
        saw01 = 1'b0;
        while (!bus.rsp_valid && lat < 20) begin
            tick();
            lat++;
            if (bus.alu_m == 2'b01) saw01 = 1'b1;
        end
        vectors++;
        if (lat != UNARY_LAT) begin
            miscompares++;
            $display("[TB] FAIL unary_latency: got %0d expected %0d", lat, UNARY_LAT);
        end
        vectors++;
        if (saw01 != UNARY_SEE01) begin
            miscompares++;
            $display("[TB] FAIL unary_ldb_cycle: got %b expected %b", saw01, UNARY_SEE01);
        end
        vectors++;
        if ({bus.rsp_f, bus.rsp_flags[2]} !== {17'h00000, 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL unary_rsp: got %h/Z=%b expected 00000/Z=1", bus.rsp_f, bus.rsp_flags[2]);
        end
        tick();
        tick();
    endtask

    task automatic test_back_to_back();
        int lat;
        bus.rsp_ready = 1'b1;
        bus.req_a     = 16'h0010;
        bus.req_b     = 16'h0020;
        bus.req_op    = 4'b0001;
        bus.req_valid = 1'b1;
        tick();
        bus.req_a  = 16'h0100;
        bus.req_b  = 16'h0023;
        bus.req_op = 4'b0010;
        tick();
        tick();
        tick();
        tick();
        vectors++;
        if ({bus.rsp_valid, bus.rsp_f, bus.rsp_flags} !== {1'b1, 17'h00030, 4'b0000}) begin
            miscompares++;
            $display("[TB] FAIL b2b_first_rsp: got %b/%h/%b expected 1/00030/0000",
                     bus.rsp_valid, bus.rsp_f, bus.rsp_flags);
        end
        tick();
        vectors++;
        if ({bus.req_ready, bus.alu_m} !== 3'b010) begin
            miscompares++;
            $display("[TB] FAIL b2b_handshake_edge: got %b/%b expected 0/10", bus.req_ready, bus.alu_m);
        end
        tick();
        vectors++;
        if ({bus.req_ready, bus.alu_m} !== 3'b110) begin
            miscompares++;
            $display("[TB] FAIL b2b_ready_rise: got %b/%b expected 1/10", bus.req_ready, bus.alu_m);
        end
        tick();
        bus.req_valid = 1'b0;
        vectors++;
        if (bus.req_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL b2b_second_accept: got %b expected 0", bus.req_ready);
        end
        tick();
        vectors++;
        if ({bus.alu_m, bus.alu_t} !== {2'b00, 16'h0100}) begin
            miscompares++;
            $display("[TB] FAIL b2b_second_lda: got %b/%h expected 00/0100", bus.alu_m, bus.alu_t);
        end
        lat = 0;
        while (!bus.rsp_valid && lat < 20) begin
            tick();
            lat++;
        end
        vectors++;
        if ({bus.rsp_valid, bus.rsp_f, bus.rsp_flags} !== {1'b1, 17'h000DD, 4'b1000}) begin
            miscompares++;
            $display("[TB] FAIL b2b_second_rsp: got %b/%h/%b expected 1/000dd/1000",
                     bus.rsp_valid, bus.rsp_f, bus.rsp_flags);
        end
        tick();
        tick();
    endtask

    // Scenario sequence and summary.
    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_add_overflow();
        test_sub_zero();
        test_backpressure();
        test_abort_recover();
        test_unary();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu16_seq.md
# alu16_seq

Bus sequencer that drives the 16-bit ALU's shared load port (operand/opcode bus `T`, load-select `M`) from a single-request valid/ready interface. It serialises operand A, operand B and the opcode onto the bus, waits a configurable settle time, and captures the ALU result and flags into a held response. It sits between the datapath control unit and the combinational ALU, and is the only block that drives the ALU's `T`/`M`.

## Interface
Parameters:
- `BIT_WIDTH`, 16, operand width; the ALU result is `BIT_WIDTH+1` bits wide.
- `SETTLE`, 1, cycles spent in WAIT before capture; legal range 1..15.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request.
- `req_a`  in  16  operand A.
- `req_b`  in  16  operand B.
- `req_op`  in  4  ALU opcode (0001 ADD … 1011 RCR).
- `alu_t`  out  16  drives the ALU `T` bus.
- `alu_m`  out  2  drives the ALU `M`: 00 = load A, 01 = load B, 11 = load op, 10 = hold.
- `alu_f`  in  17  ALU result `F`.
- `alu_c`, `alu_z`, `alu_n`, `alu_ov`  in  1 each  ALU flags.
- `rsp_valid`  out  1  response held.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_f`  out  17  captured result.
- `rsp_flags`  out  4  captured flags, ordered {C,Z,N,OV}.

## Operation
- States: IDLE, LDA, LDB, LDS, WAIT, RESP.
- `alu_t`, `alu_m`, `rsp_*` and `req_ready` are registered outputs.
- **IDLE**
  - `req_ready`=1, `alu_m`=10, `alu_t`=0.
  - On `req_valid && req_ready`, latch a, b and op internally; go to LDA.
- **LDA:** `alu_m`=00, `alu_t`=a; go to LDB.
- **LDB:** `alu_m`=01, `alu_t`=b; go to LDS.
- **LDS:** `alu_m`=11, `alu_t`={12'b0, op}; go to WAIT and load the counter with `SETTLE`.
- **WAIT**
  - `alu_m`=10, `alu_t`=0; decrement the counter.
  - On the edge where the counter is 1: capture `rsp_f`←`alu_f` and `rsp_flags`←{`alu_c`,`alu_z`,`alu_n`,`alu_ov`}, set `rsp_valid`=1, go to RESP.
- **RESP**
  - `rsp_f`, `rsp_flags` and `rsp_valid` are held stable; `alu_m`=10.
  - On `rsp_ready`: clear `rsp_valid`, go to IDLE.
- No opcode filtering. Undefined opcodes (0000, 1100–1111) are sent as-is; the ALU returns F=0 and Z=1, and this is captured.
- Flags are captured verbatim. The block never recomputes ALU flags.
- `req_ready`=0 in every state except IDLE. At most one transaction is in flight.

## Timing
- Reset values: state=IDLE, `req_ready`=1, `alu_m`=10, `alu_t`=0, `rsp_valid`=0, `rsp_f`=0, `rsp_flags`=0, counter=0.
- Bus sequence, counting edge 0 as the accept edge:
  - edge 1: LDA drive appears;
  - edge 2: LDB drive;
  - edge 3: LDS drive;
  - edges 4..3+`SETTLE`: WAIT;
  - edge 3+`SETTLE`: capture; `rsp_valid` is high from this edge.
- Request-to-`rsp_valid` latency is 3+`SETTLE` edges (2+`SETTLE` when a unary op skips LDB).
- If `rsp_ready` is already high when `rsp_valid` rises, the response completes on the next edge. Minimum RESP occupancy is 1 cycle.
- Back-to-back: `req_ready` rises on the edge after the response handshake. There is no overlap between transactions.
- `rsp_ready` while `rsp_valid`=0 is ignored. `req_valid` outside IDLE is ignored and not queued.
- Reset mid-transaction aborts immediately (asynchronous):
  - all outputs return to reset values;
  - ALU internal latches keep stale values, which is harmless because the next transaction reloads every register it uses.

## Configuration
- `ALU16_UNARY_SKIP_EN` defined:
  - opcodes 0011, 0100, 0111, 1000, 1001, 1010, 1011 (B-independent) go LDA→LDS, with no `alu_m`=01 cycle;
  - latency is 2+`SETTLE`; the ALU's B keeps its previous value.
- Undefined: every opcode passes through LDB; latency is always 3+`SETTLE`.

## Test plan
- **Reset:** assert `rst` asynchronously mid-cycle → all outputs take reset values immediately; `alu_m`=10, `req_ready`=1.
- **ADD overflow:** a=16'h7FFF, b=16'h0001, op=0001, `SETTLE`=1, ALU model attached, `rsp_ready`=1.
  - Bus shows (00,7FFF), (01,0001), (11,0001), (10,0000).
  - `rsp_valid` rises 4 edges after accept, with `rsp_f`=17'h08000 and `rsp_flags`=4'b0001.
- **SUB to zero:** a=5, b=5, op=0010 → `rsp_f`=17'h00000, `rsp_flags`=4'b1100.
- **Backpressure:** hold `rsp_ready`=0 for 10 cycles after `rsp_valid` → `rsp_f`/`rsp_flags` constant, `req_ready`=0, `alu_m`=10 throughout; a `req_valid` pulse in this window is ignored.
- **Unary op:** op=0011 (INC), a=16'hFFFF.
  - With `ALU16_UNARY_SKIP_EN`: no `alu_m`=01 cycle; latency is 3 edges.
  - Without it: `alu_m`=01 appears and latency is 4.
  - In both cases `rsp_f`=17'h00000 and Z=1.
- **Abort and recover:** assert `rst` while in LDB, release it, then issue ADD 3+4 → bus sequence restarts from LDA; `rsp_f`=17'h00007, `rsp_flags`=4'b0000.
